// File: rtl/reg_file_sb.sv
// ID-stage register file with write-through bypass, per-register pending scoreboard
// and a self-initialising sequencer that walks the array after reset.
module reg_file_sb #(
   parameter int DATA_W    = 32,
   parameter int ADDR_W    = 4,
   parameter int NUM_REGS  = 15,
   parameter int NUM_RD    = 2,
   parameter int INIT_MODE = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_busy,
   input  logic                       wb_en,
   input  logic [ADDR_W-1:0]          wb_addr,
   input  logic [DATA_W-1:0]          wb_data,
   input  logic                       issue_en,
   input  logic [ADDR_W-1:0]          issue_dest,
   output logic [NUM_REGS-1:0]        pending,
   output logic                       ready
);

   localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(NUM_REGS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

   typedef enum logic {INIT, RUN} state_t;

   state_t              state;
   logic [IDX_W-1:0]    init_cnt;
   logic [DATA_W-1:0]   regs [NUM_REGS];
   logic [DATA_W-1:0]   init_val;
   logic [NUM_REGS-1:0] pend_next;
   logic                wb_hit;
   logic                issue_hit;
   logic [IDX_W-1:0]    wb_idx;
   logic [IDX_W-1:0]    issue_idx;

   assign wb_hit    = wb_en    && ({1'b0, wb_addr}    < LIMIT);
   assign issue_hit = issue_en && ({1'b0, issue_dest} < LIMIT);
   assign wb_idx    = wb_addr[IDX_W-1:0];
   assign issue_idx = issue_dest[IDX_W-1:0];
   assign init_val  = (INIT_MODE == 0) ? DATA_W'(init_cnt) : '0;

   // A newer producer claiming the same register wins over its write-back.
   always_comb begin
      pend_next = pending;
      if (wb_hit)
         pend_next[wb_idx] = 1'b0;
      if (issue_hit)
         pend_next[issue_idx] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= INIT;
         init_cnt <= '0;
         pending  <= '0;
         ready    <= 1'b0;
      end else begin
         case (state)
            INIT: begin
               if (init_cnt == LAST_IDX) begin
                  state    <= RUN;
                  ready    <= 1'b1;
                  init_cnt <= '0;
               end else begin
                  init_cnt <= init_cnt + 1'b1;
               end
            end
            RUN: pending <= pend_next;
            default: state <= INIT;
         endcase
      end
   end

   // Storage has no reset; the sequencer fills it one entry per cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == INIT)
            regs[init_cnt] <= init_val;
         else if (wb_hit)
            regs[wb_idx] <= wb_data;
      end
   end

   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [IDX_W-1:0]  idx;
      logic              in_range;
      logic [DATA_W-1:0] data;
      logic              busy;

      assign addr     = rd_addr[p*ADDR_W +: ADDR_W];
      assign idx      = addr[IDX_W-1:0];
      assign in_range = ({1'b0, addr} < LIMIT);

      always_comb begin
         data = '0;
         busy = 1'b0;
         if (in_range) begin
            if (state == RUN && wb_en && wb_addr == addr) begin
               data = wb_data;
            end else begin
               data = regs[idx];
               busy = pending[idx];
            end
         end
         if (state == INIT)
            busy = 1'b1;
      end

      assign rd_data[p*DATA_W +: DATA_W] = data;
      assign rd_busy[p]                  = busy;
   end

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed and randomized checks of reg_file_sb against an array-based model
// of the register contents, scoreboard and init sequence.
module tb_reg_file_sb;

   localparam int DW = 32;
   localparam int AW = 4;
   localparam int NR = 15;
   localparam int NP = 2;

   logic            clk = 1'b0;
   logic            rst;
   logic [NP*AW-1:0] rd_addr;
   logic [NP*DW-1:0] rd_data;
   logic [NP-1:0]   rd_busy;
   logic            wb_en;
   logic [AW-1:0]   wb_addr;
   logic [DW-1:0]   wb_data;
   logic            issue_en;
   logic [AW-1:0]   issue_dest;
   logic [NR-1:0]   pending;
   logic            ready;

   reg_file_sb #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .NUM_RD(NP), .INIT_MODE(0)) dut (
      .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .issue_en(issue_en),
      .issue_dest(issue_dest), .pending(pending), .ready(ready)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   // Reference model
   logic [DW-1:0] m_regs [NR];
   bit            m_valid [NR];
   bit            m_pend [NR];
   bit            m_init = 1'b1;
   int            m_cnt = 0;
   bit            m_ready = 1'b0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic model_edge();
      if (rst) begin
         m_init = 1'b1; m_cnt = 0; m_ready = 1'b0;
         for (int i = 0; i < NR; i++) m_pend[i] = 1'b0;
      end else if (m_init) begin
         m_regs[m_cnt] = DW'(m_cnt);
         m_valid[m_cnt] = 1'b1;
         m_cnt++;
         if (m_cnt == NR) begin
            m_init = 1'b0; m_ready = 1'b1;
         end
      end else begin
         if (wb_en && int'(wb_addr) < NR) begin
            m_regs[wb_addr] = wb_data;
            m_pend[wb_addr] = 1'b0;
         end
         if (issue_en && int'(issue_dest) < NR) m_pend[issue_dest] = 1'b1;
      end
   endtask

   task automatic step();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outputs();
      logic [NR-1:0] exp_pend;
      for (int i = 0; i < NR; i++) exp_pend[i] = m_pend[i];
      check("ready", 64'(ready), 64'(m_ready));
      check("pending", 64'(pending), 64'(exp_pend));
      for (int p = 0; p < NP; p++) begin
         int a;
         logic [DW-1:0] ed;
         bit eb, known;
         a = int'(rd_addr[p*AW +: AW]);
         known = 1'b1;
         if (a >= NR) begin
            ed = '0; eb = m_init;
         end else if (!m_init && wb_en && int'(wb_addr) == a) begin
            ed = wb_data; eb = 1'b0;
         end else begin
            ed = m_regs[a]; known = m_valid[a]; eb = m_init ? 1'b1 : m_pend[a];
         end
         check($sformatf("rd_busy[%0d]", p), 64'(rd_busy[p]), 64'(eb));
         if (known) check($sformatf("rd_data[%0d]", p), 64'(rd_data[p*DW +: DW]), 64'(ed));
      end
   endtask

   task automatic idle();
      wb_en = 1'b0; issue_en = 1'b0; wb_addr = '0; wb_data = '0; issue_dest = '0;
   endtask

   task automatic set_rd(input int a0, input int a1);
      rd_addr = {AW'(a1), AW'(a0)};
   endtask

   // Steps until ready rises, checking every cycle; returns edge count.
   task automatic run_init(input bit poke_wb, output int n);
      n = 0;
      while (ready !== 1'b1 && n < 40) begin
         wb_en = poke_wb ? 1'($urandom_range(0, 1)) : 1'b0;
         wb_addr = 4'd2; wb_data = 32'h0BAD_0BAD;
         issue_en = poke_wb; issue_dest = 4'd2;
         #1 check_outputs();
         step();
         n++;
      end
      idle();
   endtask

   initial begin
      int n;
      logic [NR-1:0] pend_before;
      rst = 1'b1;
      idle();
      set_rd(0, 1);
      for (int i = 0; i < NR; i++) begin m_valid[i] = 1'b0; m_pend[i] = 1'b0; end
      step();
      step();
      check("reset_ready", 64'(ready), 64'd0);
      check("reset_pending", 64'(pending), 64'd0);
      check("reset_busy", 64'(rd_busy), 64'b11);

      // Init sequence after a reset pulse
      rst = 1'b0;
      run_init(1'b0, n);
      check("init_edges", 64'(n), 64'd15);
      check("ready_after_init", 64'(ready), 64'd1);
      for (int i = 0; i < NR; i++) begin
         set_rd(i, NR - 1 - i);
         #1 check_outputs();
         check($sformatf("init_val_r%0d", i), 64'(rd_data[DW-1:0]), 64'(i));
         step();
      end

      // Bypass then persistence
      set_rd(3, 0);
      wb_en = 1'b1; wb_addr = 4'd3; wb_data = 32'hDEAD_BEEF;
      #1 check_outputs();
      check("bypass_data", 64'(rd_data[DW-1:0]), 64'hDEAD_BEEF);
      step();
      idle();
      #1 check("after_write", 64'(rd_data[DW-1:0]), 64'hDEAD_BEEF);
      step();

      // Scoreboard set and clear
      set_rd(0, 5);
      issue_en = 1'b1; issue_dest = 4'd5;
      #1 check("issue_same_cycle_busy", 64'(rd_busy[1]), 64'd0);
      step();
      idle();
      #1 check("pending5_set", 64'(pending[5]), 64'd1);
      check("busy5_set", 64'(rd_busy[1]), 64'd1);
      wb_en = 1'b1; wb_addr = 4'd5; wb_data = 32'h12;
      #1 check("wb5_busy", 64'(rd_busy[1]), 64'd0);
      check("wb5_data", 64'(rd_data[DW +: DW]), 64'h12);
      step();
      idle();
      #1 check("pending5_clear", 64'(pending[5]), 64'd0);
      check("data5_after", 64'(rd_data[DW +: DW]), 64'h12);

      // Simultaneous issue and write-back on r7
      issue_en = 1'b1; issue_dest = 4'd7;
      step();
      wb_en = 1'b1; wb_addr = 4'd7; wb_data = 32'h0000_CAFE;
      issue_en = 1'b1; issue_dest = 4'd7;
      step();
      idle();
      set_rd(7, 7);
      #1 check("pending7_kept", 64'(pending[7]), 64'd1);
      check("reg7_data", 64'(rd_data[DW-1:0]), 64'h0000_CAFE);
      check_outputs();

      // Out-of-range addresses
      pend_before = pending;
      wb_en = 1'b1; wb_addr = 4'd15; wb_data = 32'h5555_5555;
      issue_en = 1'b1; issue_dest = 4'd15;
      set_rd(15, 15);
      #1 check("oor_rd_data", 64'(rd_data), 64'd0);
      check("oor_rd_busy", 64'(rd_busy), 64'd0);
      step();
      idle();
      #1 check("oor_pending", 64'(pending), 64'(pend_before));
      for (int i = 0; i < NR; i++) begin
         set_rd(i, 15);
         #1 check_outputs();
      end

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         set_rd($urandom_range(0, 15), $urandom_range(0, 15));
         wb_en = 1'($urandom_range(0, 1));
         wb_addr = AW'($urandom_range(0, 15));
         wb_data = $urandom;
         issue_en = ($urandom_range(0, 2) == 0);
         issue_dest = AW'($urandom_range(0, 15));
         #1 check_outputs();
         step();
      end
      idle();

      // Reset mid-init with write-back and issue noise
      rst = 1'b1;
      step();
      rst = 1'b0;
      set_rd(2, 6);
      for (int i = 0; i < 6; i++) begin
         wb_en = 1'($urandom_range(0, 1)); wb_addr = 4'd2; wb_data = 32'h0BAD_0BAD;
         issue_en = 1'b1; issue_dest = 4'd2;
         #1 check_outputs();
         step();
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      run_init(1'b1, n);
      check("reinit_edges", 64'(n), 64'd15);
      set_rd(2, 6);
      #1 check("reinit_r2", 64'(rd_data[DW-1:0]), 64'd2);
      check("reinit_r6", 64'(rd_data[DW +: DW]), 64'd6);
      check("reinit_pending", 64'(pending), 64'd0);
      check_outputs();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
